// File: rtl/array_multiplier_pkg.sv
// Shared constants and types for the array multiplier.
//   AM_WIDTH_DEFAULT : default operand width in bits
//   am_operand_t     : operand vector sized from AM_WIDTH_DEFAULT
//   am_product_t     : full-width product vector (2 * AM_WIDTH_DEFAULT bits)
package array_multiplier_pkg;

    localparam int unsigned AM_WIDTH_DEFAULT = 4;

    typedef logic [AM_WIDTH_DEFAULT-1:0]   am_operand_t;
    typedef logic [2*AM_WIDTH_DEFAULT-1:0] am_product_t;

endpackage

// File: rtl/am_full_adder.sv
// One combinational full-adder cell of the multiplier array.
// Ports:
//   a, b, cin : addend bits and carry in
//   sum, cout : sum bit and carry out
module am_full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/array_multiplier.sv
// Unsigned WIDTH x WIDTH array multiplier with a registered 2*WIDTH-bit product.
// Partial products are AND gates; rows of am_full_adder cells with ripple carry
// accumulate them. Result appears one cycle after in_valid (two cycles when the
// optional mid-array register stage is built).
// Ports:
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset, clears Product and out_valid
//   in_valid  : A/B carry an operand pair this cycle
//   A, B      : unsigned operands
//   Product   : registered product A*B, holds when no new result
//   out_valid : Product holds a new result this cycle
// Build option:
//   ARRAY_MULTIPLIER_PIPE_EN : adds a register stage after row WIDTH/2 (latency 2)
module array_multiplier
    import array_multiplier_pkg::*;
#(
    parameter int WIDTH = AM_WIDTH_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic [2*WIDTH-1:0] Product,
    output logic               out_valid
);

    localparam int MID = WIDTH / 2;

    // row_s[i] is the (WIDTH+1)-bit running sum after row i; bit 0 is final
    // product bit i, bits [WIDTH:1] feed the next row.
    logic [WIDTH:0]     row_s [WIDTH];
    logic [MID-1:0]     lo_f;

    // Signals seen by the back half of the array (rows > MID) and the output.
    logic [WIDTH-1:0]   a_b;
    logic [WIDTH-1:0]   b_b;
    logic [WIDTH:0]     s_mid_b;
    logic [MID-1:0]     lo_b;
    logic               valid_b;

    logic [2*WIDTH-1:0] prod_c;
    logic [2*WIDTH-1:0] product_d, product_q;
    logic               out_valid_d, out_valid_q;

    assign row_s[0] = {1'b0, A & {WIDTH{B[0]}}};

    for (genvar i = 0; i < MID; i++) begin : g_lo
        assign lo_f[i] = row_s[i][0];
    end

    for (genvar i = 1; i < WIDTH; i++) begin : g_row
        logic [WIDTH-1:0] row_a;
        logic             row_b;
        logic [WIDTH-1:0] prev;
        logic [WIDTH-1:0] s;
        logic [WIDTH-1:0] c;
        logic [WIDTH-1:0] cin_v;

        if (i <= MID) begin : g_front
            assign row_a = A;
            assign row_b = B[i];
            assign prev  = row_s[i-1][WIDTH:1];
        end else begin : g_back
            assign row_a = a_b;
            assign row_b = b_b[i];
            if (i == MID + 1) begin : g_from_mid
                assign prev = s_mid_b[WIDTH:1];
            end else begin : g_from_row
                assign prev = row_s[i-1][WIDTH:1];
            end
        end

        assign cin_v = {c[WIDTH-2:0], 1'b0};

        for (genvar j = 0; j < WIDTH; j++) begin : g_cell
            am_full_adder u_fa (
                .a    (prev[j]),
                .b    (row_a[j] & row_b),
                .cin  (cin_v[j]),
                .sum  (s[j]),
                .cout (c[j])
            );
        end

        assign row_s[i] = {c[WIDTH-1], s};
    end

    // Low product bits come from the row that finalised them.
    for (genvar i = 0; i < WIDTH - 1; i++) begin : g_prod_lo
        if (i < MID) begin : g_pre
            assign prod_c[i] = lo_b[i];
        end else if (i == MID) begin : g_at
            assign prod_c[i] = s_mid_b[0];
        end else begin : g_post
            assign prod_c[i] = row_s[i][0];
        end
    end

    if (WIDTH - 1 == MID) begin : g_top_mid
        assign prod_c[2*WIDTH-1:WIDTH-1] = s_mid_b;
    end else begin : g_top_row
        assign prod_c[2*WIDTH-1:WIDTH-1] = row_s[WIDTH-1];
    end

`ifdef ARRAY_MULTIPLIER_PIPE_EN
    // Mid-array stage: operands for the remaining rows travel with the partial sum.
    logic [WIDTH-1:0] a_d, a_q;
    logic [WIDTH-1:0] b_d, b_q;
    logic [WIDTH:0]   s_mid_d, s_mid_q;
    logic [MID-1:0]   lo_d, lo_q;
    logic             valid_mid_d, valid_mid_q;

    always_comb begin
        a_d         = A;
        b_d         = B;
        s_mid_d     = row_s[MID];
        lo_d        = lo_f;
        valid_mid_d = in_valid;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q         <= '0;
            b_q         <= '0;
            s_mid_q     <= '0;
            lo_q        <= '0;
            valid_mid_q <= 1'b0;
        end else begin
            a_q         <= a_d;
            b_q         <= b_d;
            s_mid_q     <= s_mid_d;
            lo_q        <= lo_d;
            valid_mid_q <= valid_mid_d;
        end
    end

    assign a_b     = a_q;
    assign b_b     = b_q;
    assign s_mid_b = s_mid_q;
    assign lo_b    = lo_q;
    assign valid_b = valid_mid_q;
`else
    assign a_b     = A;
    assign b_b     = B;
    assign s_mid_b = row_s[MID];
    assign lo_b    = lo_f;
    assign valid_b = in_valid;
`endif

    always_comb begin
        product_d   = product_q;
        out_valid_d = valid_b;
        if (valid_b) begin
            product_d = prod_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            product_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            product_q   <= product_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign Product   = product_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_array_multiplier.sv
// Scoreboard bench for array_multiplier at the default width. The driver pushes
// the arithmetic product and the cycle it is due; a negedge monitor pops and
// compares whenever out_valid is high and checks Product holds otherwise.
module tb_array_multiplier;
    import array_multiplier_pkg::*;

    localparam int W = AM_WIDTH_DEFAULT;
`ifdef ARRAY_MULTIPLIER_PIPE_EN
    localparam int unsigned LAT = 2;
`else
    localparam int unsigned LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    am_operand_t a_in = '0;
    am_operand_t b_in = '0;
    am_product_t product;
    logic        out_valid;

    typedef struct {
        am_product_t p;
        int unsigned due;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    am_product_t last_exp = '0;

    array_multiplier #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .A         (a_in),
        .B         (b_in),
        .Product   (product),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(string name, longint unsigned act, longint unsigned req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endfunction

    // Drive one cycle of input; track=0 issues a pair that must never be reported.
    task automatic issue(input int a, input int b, input bit v, input bit track);
        exp_t e;
        @(posedge clk);
        #1;
        in_valid = v;
        a_in     = am_operand_t'(a);
        b_in     = am_operand_t'(b);
        if (v && track) begin
            e.p   = am_product_t'(a * b);
            e.due = cyc + LAT;
            exp_q.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) issue(0, 0, 1'b0, 1'b0);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("out_valid_without_issue", out_valid, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("product", product, e.p);
                    check("result_cycle", cyc, e.due);
                    last_exp = e.p;
                end
            end else begin
                check("hold_product", product, last_exp);
            end
        end
    end

    initial begin
        // Reset asserted asynchronously, checked before any clock edge.
        #2 rst_n = 1'b0;
        #1;
        check("reset_product", product, 0);
        check("reset_out_valid", out_valid, 0);
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;

        // Single operations separated by idle cycles.
        issue(3, 5, 1'b1, 1'b1);   idle(2);
        issue(13, 2, 1'b1, 1'b1);  idle(2);
        issue(6, 10, 1'b1, 1'b1);  idle(2);
        issue(15, 15, 1'b1, 1'b1); idle(2);

        // Back-to-back issue.
        issue(3, 5, 1'b1, 1'b1);
        issue(13, 2, 1'b1, 1'b1);
        issue(6, 10, 1'b1, 1'b1);
        issue(15, 15, 1'b1, 1'b1);
        idle(3);

        // Zero operands.
        issue(0, 9, 1'b1, 1'b1);
        issue(9, 0, 1'b1, 1'b1);
        idle(3);

        // Result 60 must hold through idle cycles.
        issue(6, 10, 1'b1, 1'b1);
        idle(4);

        // Reset while 15*15 is in flight; it must never be reported.
`ifdef ARRAY_MULTIPLIER_PIPE_EN
        issue(15, 15, 1'b1, 1'b0);
        @(posedge clk);
        #1 in_valid = 1'b0;
`else
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        a_in     = 4'd15;
        b_in     = 4'd15;
`endif
        #2 rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        check("inflight_reset_product", product, 0);
        check("inflight_reset_out_valid", out_valid, 0);
        last_exp = '0;
        #2 rst_n = 1'b1;
        idle(4);

        // First operation after reset, then exhaustive back-to-back sweep.
        issue(7, 11, 1'b1, 1'b1);
        for (int a = 0; a < (1 << W); a++) begin
            for (int b = 0; b < (1 << W); b++) begin
                issue(a, b, 1'b1, 1'b1);
            end
        end
        idle(2);

        // Random operands with random gaps.
        for (int i = 0; i < 300; i++) begin
            issue(int'($urandom_range(0, (1 << W) - 1)), int'($urandom_range(0, (1 << W) - 1)),
                  $urandom_range(0, 3) != 0, 1'b1);
        end

        idle(int'(LAT) + 3);
        check("results_outstanding", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
